// File: rtl/life_pkg.sv
// Shared Game-of-Life constants, FSM encoding and the B3/S23 rule.
// The VGA cell-lookup stage imports the same board geometry so both ends agree on indexing.
package life_pkg;

   localparam int ROWS  = 16;
   localparam int COLS  = 16;
   localparam int CELLS = ROWS * COLS;
   localparam int IDX_W = $clog2(CELLS);
   localparam int ROW_W = $clog2(ROWS);
   localparam int COL_W = $clog2(COLS);
   localparam int GEN_W = 16;

   localparam logic [3:0] BIRTH_N   = 4'd3;
   localparam logic [3:0] SURVIVE_N = 4'd2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   function automatic logic life_rule(input logic alive, input logic [3:0] n);
      return (n == BIRTH_N) | (alive & (n == SURVIVE_N));
   endfunction

endpackage

// File: rtl/life_neighbour_count.sv
// Combinational live-neighbour count (0..8) for one cell of the committed board.
// WRAP=1 wraps edges toroidally; WRAP=0 treats off-board neighbours as dead.
module life_neighbour_count
   import life_pkg::*;
#(
   parameter int ROWS     = life_pkg::ROWS,
   parameter int COLS     = life_pkg::COLS,
   parameter bit WRAP     = 1'b1,
   localparam int ROW_BITS = $clog2(ROWS),
   localparam int COL_BITS = $clog2(COLS)
)(
   input  logic [ROWS*COLS-1:0] board,
   input  logic [ROW_BITS-1:0]  row,
   input  logic [COL_BITS-1:0]  col,
   output logic [3:0]           n
);

   // Row/col wrap falls out of truncating to the power-of-two field widths.
   always_comb begin
      n = '0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            int r_i;
            int c_i;
            logic on_board;
            logic [ROW_BITS-1:0] r_w;
            logic [COL_BITS-1:0] c_w;
            r_i      = int'(row) + dr;
            c_i      = int'(col) + dc;
            on_board = (r_i >= 0) && (r_i < ROWS) && (c_i >= 0) && (c_i < COLS);
            r_w      = ROW_BITS'(r_i);
            c_w      = COL_BITS'(c_i);
            if ((dr != 0 || dc != 0) && (WRAP || on_board)) begin
               n = n + 4'(board[{r_w, c_w}]);
            end
         end
      end
   end

endmodule

// File: rtl/life_next_gen_engine.sv
// Game-of-Life generation engine: scans one cell per clock into a shadow board
// and commits the whole generation at once so downstream never sees a partial update.
module life_next_gen_engine
   import life_pkg::*;
#(
   parameter int ROWS  = life_pkg::ROWS,
   parameter int COLS  = life_pkg::COLS,
   parameter bit WRAP  = 1'b1,
   parameter int GEN_W = life_pkg::GEN_W
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [ROWS*COLS-1:0] seed_board,
   input  logic                 step,
   output logic [ROWS*COLS-1:0] board,
   output logic                 busy,
   output logic                 done,
   output logic [GEN_W-1:0]     gen_count
);

   localparam int CELL_CNT = ROWS * COLS;
   localparam int IDX_BITS = $clog2(CELL_CNT);
   localparam int ROW_BITS = $clog2(ROWS);
   localparam int COL_BITS = $clog2(COLS);
   localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(CELL_CNT - 1);

   state_t                state;
   state_t                state_nxt;
   logic [IDX_BITS-1:0]   idx;
   logic [CELL_CNT-1:0]   shadow;
   logic [ROW_BITS-1:0]   row;
   logic [COL_BITS-1:0]   col;
   logic [3:0]            n;
   logic                  next_cell;

   assign row = idx[IDX_BITS-1:COL_BITS];
   assign col = idx[COL_BITS-1:0];

   // Neighbours always come from the committed board, never the shadow.
   life_neighbour_count #(
      .ROWS (ROWS),
      .COLS (COLS),
      .WRAP (WRAP)
   ) u_neighbour_count (
      .board (board),
      .row   (row),
      .col   (col),
      .n     (n)
   );

   assign next_cell = life_rule(board[idx], n);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Load overrides everything, including a step in the same cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (step) state_nxt = SCAN;
         SCAN:    if (idx == LAST_IDX) state_nxt = COMMIT;
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (load) begin
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         board     <= '0;
         shadow    <= '0;
         idx       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         gen_count <= '0;
      end else begin
         done <= 1'b0;
         if (load) begin
            board     <= seed_board;
            gen_count <= '0;
            busy      <= 1'b0;
            idx       <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (step) begin
                     idx  <= '0;
                     busy <= 1'b1;
                  end
               end
               SCAN: begin
                  shadow[idx] <= next_cell;
                  idx         <= idx + 1'b1;
               end
               COMMIT: begin
                  board     <= shadow;
                  gen_count <= gen_count + 1'b1;
                  done      <= 1'b1;
                  busy      <= 1'b0;
               end
               default: begin
                  busy <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_life_next_gen_engine.sv
// Self-checking bench: a toroidal engine and a bounded-edge engine with a 2-bit
// generation counter run side by side against a 2-D Game-of-Life reference model.
module tb_life_next_gen_engine;

   localparam int N = 256;

   logic           clk = 1'b0;
   logic           rst;
   logic           load;
   logic           step;
   logic [N-1:0]   seed_board;

   logic [N-1:0]   a_board;
   logic           a_busy;
   logic           a_done;
   logic [15:0]    a_gen;
   logic [N-1:0]   b_board;
   logic           b_busy;
   logic           b_done;
   logic [1:0]     b_gen;

   int             checks = 0;
   int             failures = 0;
   logic [N-1:0]   exp_a;
   logic [N-1:0]   exp_b;
   int             exp_gen_a;
   int             exp_gen_b;

   always #5 clk = ~clk;

   life_next_gen_engine #(.ROWS(16), .COLS(16), .WRAP(1'b1), .GEN_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .seed_board (seed_board),
      .step       (step),
      .board      (a_board),
      .busy       (a_busy),
      .done       (a_done),
      .gen_count  (a_gen)
   );

   life_next_gen_engine #(.ROWS(16), .COLS(16), .WRAP(1'b0), .GEN_W(2)) dut_nowrap (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .seed_board (seed_board),
      .step       (step),
      .board      (b_board),
      .busy       (b_busy),
      .done       (b_done),
      .gen_count  (b_gen)
   );

   // Reference: plain 2-D neighbourhood walk with modulo or bounds check.
   function automatic logic [N-1:0] model_next(input logic [N-1:0] cur, input bit wrap);
      logic [N-1:0] nb;
      nb = '0;
      for (int r = 0; r < 16; r++) begin
         for (int c = 0; c < 16; c++) begin
            int cnt;
            cnt = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  int rr;
                  int cc;
                  if (dr == 0 && dc == 0) continue;
                  rr = r + dr;
                  cc = c + dc;
                  if (wrap) begin
                     rr = (rr + 16) % 16;
                     cc = (cc + 16) % 16;
                     cnt += int'(cur[rr*16+cc]);
                  end else if (rr >= 0 && rr < 16 && cc >= 0 && cc < 16) begin
                     cnt += int'(cur[rr*16+cc]);
                  end
               end
            end
            nb[r*16+c] = (cnt == 3) || (cur[r*16+c] && cnt == 2);
         end
      end
      return nb;
   endfunction

   function automatic logic [N-1:0] random_board();
      logic [N-1:0] v;
      for (int w = 0; w < N/32; w++) v[w*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic apply_load(input logic [N-1:0] s);
      @(negedge clk);
      seed_board = s;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      exp_a = s;
      exp_b = s;
      exp_gen_a = 0;
      exp_gen_b = 0;
   endtask

   task automatic start_step();
      @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
   endtask

   // Counts edges after the step edge until done; lat stays past 257 on timeout.
   task automatic wait_done(output int lat);
      lat = 0;
      while (lat < 400) begin
         @(negedge clk);
         lat++;
         if (a_done) break;
      end
   endtask

   task automatic advance_model();
      exp_a = model_next(exp_a, 1'b1);
      exp_b = model_next(exp_b, 1'b0);
      exp_gen_a++;
      exp_gen_b++;
   endtask

   task automatic test_reset();
      int lat;
      rst = 1'b0; load = 1'b0; step = 1'b0; seed_board = '0;
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({a_board, a_busy, a_done, a_gen} !== '0 || {b_board, b_busy, b_done, b_gen} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_start: a_gen=%0h a_busy=%0b b_gen=%0h required all zero", a_gen, a_busy, b_gen);
      end
      @(negedge clk);
      rst = 1'b0;
      apply_load(random_board());
      start_step();
      wait_done(lat);
      advance_model();
      start_step();
      repeat (30) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (a_board !== '0 || a_busy !== 1'b0 || a_done !== 1'b0 || a_gen !== 16'd0 ||
          b_board !== '0 || b_busy !== 1'b0 || b_gen !== 2'd0) begin
         failures++;
         $display("[TB] FAIL reset_mid_scan: a_gen=%0h a_busy=%0b b_gen=%0h required all zero", a_gen, a_busy, b_gen);
      end
      @(negedge clk);
      rst = 1'b0;
      exp_a = '0; exp_b = '0; exp_gen_a = 0; exp_gen_b = 0;
      start_step();
      wait_done(lat);
      advance_model();
      checks++;
      if (lat !== 257 || a_board !== '0 || a_gen !== 16'd1 || b_gen !== 2'd1) begin
         failures++;
         $display("[TB] FAIL reset_first_step: lat=%0d a_gen=%0d b_gen=%0d required lat=257 board=0 gen=1", lat, a_gen, b_gen);
      end
   endtask

   task automatic test_blinker();
      logic [N-1:0] horiz;
      logic [N-1:0] vert;
      int lat;
      horiz = '0; horiz[118] = 1'b1; horiz[119] = 1'b1; horiz[120] = 1'b1;
      vert  = '0; vert[103]  = 1'b1; vert[119]  = 1'b1; vert[135]  = 1'b1;
      apply_load(horiz);
      start_step();
      checks++;
      if (a_busy !== 1'b1 || b_busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL blinker_busy: a_busy=%0b b_busy=%0b required 1", a_busy, b_busy);
      end
      wait_done(lat);
      advance_model();
      checks++;
      if (lat !== 257 || a_board !== vert || b_board !== vert || a_gen !== 16'd1 || b_done !== 1'b1) begin
         failures++;
         $display("[TB] FAIL blinker_gen1: lat=%0d a_gen=%0d b_done=%0b board_ok=%0b required lat=257 gen=1", lat, a_gen, b_done, a_board === vert);
      end
      @(negedge clk);
      checks++;
      if (a_done !== 1'b0 || b_done !== 1'b0 || a_busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL blinker_done_width: a_done=%0b b_done=%0b a_busy=%0b required 0", a_done, b_done, a_busy);
      end
      start_step();
      wait_done(lat);
      advance_model();
      checks++;
      if (lat !== 257 || a_board !== horiz || a_gen !== 16'd2 || b_board !== horiz) begin
         failures++;
         $display("[TB] FAIL blinker_gen2: lat=%0d a_gen=%0d required lat=257 gen=2 board=horizontal", lat, a_gen);
      end
   endtask

   task automatic test_corner_wrap();
      logic [N-1:0] corners;
      int lat;
      corners = '0; corners[0] = 1'b1; corners[15] = 1'b1; corners[240] = 1'b1; corners[255] = 1'b1;
      apply_load(corners);
      start_step();
      wait_done(lat);
      advance_model();
      checks++;
      if (a_board !== corners) begin
         failures++;
         $display("[TB] FAIL corner_wrap: a_board=%h required %h", a_board, corners);
      end
      checks++;
      if (b_board !== '0) begin
         failures++;
         $display("[TB] FAIL corner_nowrap: b_board=%h required 0", b_board);
      end
   endtask

   task automatic test_step_ignored();
      int done_cnt;
      int first_done;
      int late_busy;
      apply_load(random_board());
      start_step();
      done_cnt = 0; first_done = 0; late_busy = 0;
      for (int k = 1; k <= 600; k++) begin
         if (k == 100) step = 1'b1;
         if (k == 101) step = 1'b0;
         @(negedge clk);
         if (a_done) begin
            done_cnt++;
            if (first_done == 0) first_done = k;
         end
         if (k >= 257 && a_busy) late_busy++;
      end
      advance_model();
      checks++;
      if (done_cnt !== 1 || first_done !== 257 || late_busy !== 0 || a_gen !== 16'd1 || a_board !== exp_a) begin
         failures++;
         $display("[TB] FAIL step_while_busy: dones=%0d first=%0d late_busy=%0d a_gen=%0d required 1/257/0/1", done_cnt, first_done, late_busy, a_gen);
      end
   endtask

   task automatic test_load_abort();
      logic [N-1:0] seed2;
      int dones;
      int busy_seen;
      int lat;
      apply_load(random_board());
      start_step();
      repeat (50) @(negedge clk);
      seed2 = random_board();
      seed_board = seed2;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      exp_a = seed2; exp_b = seed2; exp_gen_a = 0; exp_gen_b = 0;
      checks++;
      if (a_board !== seed2 || a_gen !== 16'd0 || a_busy !== 1'b0 || a_done !== 1'b0 || b_busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL load_abort: a_gen=%0d a_busy=%0b a_done=%0b board_ok=%0b required gen=0 busy=0 done=0", a_gen, a_busy, a_done, a_board === seed2);
      end
      dones = 0; busy_seen = 0;
      repeat (300) begin
         @(negedge clk);
         if (a_done || b_done) dones++;
         if (a_busy || b_busy) busy_seen++;
      end
      checks++;
      if (dones !== 0 || busy_seen !== 0 || a_board !== seed2) begin
         failures++;
         $display("[TB] FAIL load_abort_quiet: dones=%0d busy_cycles=%0d required 0", dones, busy_seen);
      end
      start_step();
      wait_done(lat);
      advance_model();
      checks++;
      if (lat !== 257 || a_board !== exp_a || b_board !== exp_b || a_gen !== 16'd1) begin
         failures++;
         $display("[TB] FAIL load_abort_restep: lat=%0d a_gen=%0d a_ok=%0b b_ok=%0b required model", lat, a_gen, a_board === exp_a, b_board === exp_b);
      end
   endtask

   task automatic test_load_and_step();
      logic [N-1:0] seed3;
      int busy_seen;
      seed3 = random_board();
      @(negedge clk);
      seed_board = seed3;
      load = 1'b1;
      step = 1'b1;
      @(negedge clk);
      load = 1'b0;
      step = 1'b0;
      exp_a = seed3; exp_b = seed3; exp_gen_a = 0; exp_gen_b = 0;
      busy_seen = 0;
      repeat (6) begin
         if (a_busy || b_busy || a_done) busy_seen++;
         @(negedge clk);
      end
      checks++;
      if (a_board !== seed3 || b_board !== seed3 || a_gen !== 16'd0 || busy_seen !== 0) begin
         failures++;
         $display("[TB] FAIL load_and_step: a_gen=%0d busy_cycles=%0d board_ok=%0b required gen=0 busy=0", a_gen, busy_seen, a_board === seed3);
      end
   endtask

   task automatic test_gen_wrap();
      int lat;
      apply_load(random_board());
      for (int g = 1; g <= 4; g++) begin
         start_step();
         wait_done(lat);
         advance_model();
         checks++;
         if (lat !== 257 || b_gen !== 2'(exp_gen_b) || a_gen !== 16'(exp_gen_a) || b_board !== exp_b) begin
            failures++;
            $display("[TB] FAIL gen_wrap_%0d: lat=%0d a_gen=%0d b_gen=%0d required a=%0d b=%0d", g, lat, a_gen, b_gen, exp_gen_a, exp_gen_a % 4);
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      apply_load(random_board());
      start_step();
      wait_done(lat);
      advance_model();
      for (int i = 0; i < 3; i++) begin
         step = 1'b1;
         @(negedge clk);
         step = 1'b0;
         checks++;
         if (a_busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL back_to_back_accept_%0d: a_busy=%0b required 1", i, a_busy);
         end
         wait_done(lat);
         advance_model();
         checks++;
         if (lat !== 257 || a_board !== exp_a || b_board !== exp_b || a_gen !== 16'(exp_gen_a)) begin
            failures++;
            $display("[TB] FAIL back_to_back_%0d: lat=%0d a_gen=%0d a_ok=%0b b_ok=%0b required model", i, lat, a_gen, a_board === exp_a, b_board === exp_b);
         end
      end
   endtask

   task automatic test_random();
      int lat;
      for (int t = 0; t < 5; t++) begin
         apply_load(random_board());
         for (int g = 0; g < int'($urandom_range(2, 1)); g++) begin
            start_step();
            wait_done(lat);
            advance_model();
            checks++;
            if (lat !== 257 || a_board !== exp_a || b_board !== exp_b ||
                a_gen !== 16'(exp_gen_a) || b_gen !== 2'(exp_gen_b)) begin
               failures++;
               $display("[TB] FAIL random_%0d_%0d: lat=%0d a_ok=%0b b_ok=%0b a_gen=%0d required lat=257 gen=%0d", t, g, lat, a_board === exp_a, b_board === exp_b, a_gen, exp_gen_a);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_blinker();
      test_corner_wrap();
      test_step_ignored();
      test_load_abort();
      test_load_and_step();
      test_gen_wrap();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
